// File: rtl/mult_iter_pkg.sv
// mult_iter_pkg: FSM state type, default widths and elaboration helpers for mult_iter_param.
package mult_iter_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int DEF_A_W = 32;
  localparam int DEF_B_W = 32;
  localparam int DEF_DIG_W = 16;
  function automatic bit widths_ok(input int aw, input int bw, input int dw);
    return dw >= 1 && aw % dw == 0 && bw % dw == 0;
  endfunction
  function automatic int n_digits(input int w, input int dw);
    return dw >= 1 ? w / dw : 1;
  endfunction
  function automatic int n_pairs(input int aw, input int bw, input int dw);
    return n_digits(aw, dw) * n_digits(bw, dw);
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mult_iter_param_if.sv
// mult_iter_param_if: start/busy/done control and operand/product bus; acc exists only with MULT_ITER_ACC_EN.
interface mult_iter_param_if import mult_iter_pkg::*; #(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W
);
  localparam int P_W = A_W + B_W;
  logic start;
  logic sgn;
`ifdef MULT_ITER_ACC_EN
  logic acc;
`endif
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic busy;
  logic done;
  logic [P_W-1:0] product;
`ifdef MULT_ITER_ACC_EN
  modport master(output start, sgn, acc, a, b, input busy, done, product);
  modport slave(input start, sgn, acc, a, b, output busy, done, product);
`else
  modport master(output start, sgn, a, b, input busy, done, product);
  modport slave(input start, sgn, a, b, output busy, done, product);
`endif
endinterface

// File: rtl/mult_iter_fsm.sv
// mult_iter_fsm: IDLE/CALC/FIX sequencer walking digit pairs (i,j) j-fastest; owns busy, done and datapath enables.
module mult_iter_fsm import mult_iter_pkg::*; #(
  parameter int NA = 2,
  parameter int NB = 2,
  localparam int IW = cnt_w(NA),
  localparam int JW = cnt_w(NB)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          ld,
  output logic          add_en,
  output logic          fix_en,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j
);
  state_t state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic busy_q, busy_d, done_q, done_d;
  logic last_i, last_j;
  always_comb begin
    last_i = i_q == IW'(NA - 1);
    last_j = j_q == JW'(NB - 1);
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    ld = 1'b0;
    add_en = 1'b0;
    fix_en = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        ld = 1'b1;
        i_d = '0;
        j_d = '0;
        state_d = CALC;
      end
      CALC: begin
        add_en = 1'b1;
        j_d = last_j ? '0 : j_q + 1'b1;
        i_d = last_j ? (last_i ? '0 : i_q + 1'b1) : i_q;
        state_d = last_i && last_j ? FIX : CALC;
      end
      FIX: begin
        fix_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_q == FIX;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign busy = busy_q;
  assign done = done_q;
  assign i = i_q;
  assign j = j_q;
endmodule

// File: rtl/mult_iter_param.sv
// mult_iter_param: A_W x B_W iterative signed/unsigned multiplier, one DIG_W x DIG_W partial product per cycle.
// Define MULT_ITER_ACC_EN to add the acc input that adds the result onto the previously held product.
module mult_iter_param import mult_iter_pkg::*; #(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W,
  parameter int DIG_W = DEF_DIG_W
) (
  input logic clk,
  input logic reset,
  mult_iter_param_if.slave bus
);
  localparam int P_W = A_W + B_W;
  localparam int NA = n_digits(A_W, DIG_W);
  localparam int NB = n_digits(B_W, DIG_W);
  localparam int IW = cnt_w(NA);
  localparam int JW = cnt_w(NB);
  if (!widths_ok(A_W, B_W, DIG_W)) begin : g_bad_widths
    $error("mult_iter_param: A_W and B_W must be multiples of DIG_W, DIG_W >= 1");
  end
  logic busy, done, ld, add_en, fix_en, accm_in;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [A_W-1:0] amag_q, amag_d;
  logic [B_W-1:0] bmag_q, bmag_d;
  logic neg_q, neg_d, accm_q, accm_d;
  logic [P_W-1:0] acc_q, acc_d, product_q, product_d, pp, res;
  logic [DIG_W-1:0] a_dig, b_dig;
`ifdef MULT_ITER_ACC_EN
  assign accm_in = bus.acc;
`else
  assign accm_in = 1'b0;
`endif
  mult_iter_fsm #(.NA(NA), .NB(NB)) u_fsm (
    .clk(clk),
    .reset(reset),
    .start(bus.start),
    .busy(busy),
    .done(done),
    .ld(ld),
    .add_en(add_en),
    .fix_en(fix_en),
    .i(i),
    .j(j)
  );
  // Operands are held as magnitudes, so the most negative value maps to 2^(W-1) without overflow.
  always_comb begin
    a_dig = DIG_W'(amag_q >> (int'(i) * DIG_W));
    b_dig = DIG_W'(bmag_q >> (int'(j) * DIG_W));
    pp = (P_W'(a_dig) * P_W'(b_dig)) << ((int'(i) + int'(j)) * DIG_W);
    res = neg_q ? -acc_q : acc_q;
    amag_d = ld ? (bus.sgn && bus.a[A_W-1] ? -bus.a : bus.a) : amag_q;
    bmag_d = ld ? (bus.sgn && bus.b[B_W-1] ? -bus.b : bus.b) : bmag_q;
    neg_d = ld ? bus.sgn & (bus.a[A_W-1] ^ bus.b[B_W-1]) : neg_q;
    accm_d = ld ? accm_in : accm_q;
    acc_d = ld ? '0 : add_en ? acc_q + pp : acc_q;
    product_d = ld && !accm_in ? '0 : fix_en ? (accm_q ? product_q + res : res) : product_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      amag_q <= '0;
      bmag_q <= '0;
      neg_q <= 1'b0;
      accm_q <= 1'b0;
      acc_q <= '0;
      product_q <= '0;
    end else begin
      amag_q <= amag_d;
      bmag_q <= bmag_d;
      neg_q <= neg_d;
      accm_q <= accm_d;
      acc_q <= acc_d;
      product_q <= product_d;
    end
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.product = product_q;
endmodule

// File: tb/tb_mult_iter_param.sv
// tb_mult_iter_param: directed vectors on a default (DIG_W=16) and a DIG_W=8 instance, with a
// cycle-level scoreboard of the default instance checked every cycle.
module tb_mult_iter_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic acc_drv = 1'b0;
  bit scan = 1'b0;
  int errs = 0;
  int checks = 0;
`ifdef MULT_ITER_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif
  localparam int LAT0 = 5;
  mult_iter_param_if #(.A_W(32), .B_W(32)) bus0 ();
  mult_iter_param_if #(.A_W(32), .B_W(32)) bus1 ();
  mult_iter_param #(.A_W(32), .B_W(32), .DIG_W(16)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  mult_iter_param #(.A_W(32), .B_W(32), .DIG_W(8)) u1 (.clk(clk), .reset(reset), .bus(bus1));
`ifdef MULT_ITER_ACC_EN
  assign bus0.acc = acc_drv;
  assign bus1.acc = 1'b0;
`endif
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] x, input logic [31:0] y);
    return s ? 64'(longint'($signed(x)) * longint'($signed(y))) : 64'(x) * 64'(y);
  endfunction

  // Scoreboard: an accepted start yields the result LAT0 edges later; start while busy is dropped.
  int m_rem;
  logic m_done, m_acc;
  logic [63:0] m_prod, m_res;
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_rem <= 0;
      m_done <= 1'b0;
      m_acc <= 1'b0;
      m_prod <= '0;
      m_res <= '0;
    end else begin
      m_done <= m_rem == 1;
      if (m_rem == 0 && bus0.start) begin
        m_rem <= LAT0;
        m_res <= ref_mul(bus0.sgn, bus0.a, bus0.b);
        m_acc <= ACC_EN && acc_drv;
        if (!(ACC_EN && acc_drv)) m_prod <= '0;
      end else if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_prod <= m_acc ? m_prod + m_res : m_res;
      end
    end

  always @(negedge clk)
    if (scan && reset) begin
      chk("model busy", 64'(bus0.busy), 64'(m_rem != 0));
      chk("model done", 64'(bus0.done), 64'(m_done));
      chk("model product", bus0.product, m_prod);
    end

  task automatic go(input bit s, input logic [31:0] x, input logic [31:0] y, input bit ac);
    bus0.start = 1'b1;
    bus0.sgn = s;
    bus0.a = x;
    bus0.b = y;
    acc_drv = ac;
  endtask

  // Call right after go(); returns on the done cycle. inj >= 0 pulses a stray start at that cycle.
  task automatic finish_op(input string nm, input logic [63:0] exp, input int inj);
    int n = 0;
    int bc = 0;
    @(negedge clk);
    bus0.start = 1'b0;
    while (!bus0.done && n < 40) begin
      if (bus0.busy) bc++;
      bus0.start = n == inj;
      if (n == inj) begin
        bus0.a = $urandom;
        bus0.b = $urandom;
        bus0.sgn = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    bus0.start = 1'b0;
    chk({nm, " latency"}, 64'(n), 64'(LAT0));
    chk({nm, " busy cycles"}, 64'(bc), 64'(LAT0));
    chk({nm, " product"}, bus0.product, exp);
  endtask

  task automatic op(input bit s, input logic [31:0] x, input logic [31:0] y, input bit ac,
                    input string nm, input logic [63:0] exp);
    @(negedge clk);
    go(s, x, y, ac);
    finish_op(nm, exp, -1);
  endtask

  initial begin
    int n;
    bus0.start = 1'b0;
    bus0.sgn = 1'b0;
    bus0.a = '0;
    bus0.b = '0;
    bus1.start = 1'b0;
    bus1.sgn = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    #1 reset = 1'b0;
    #1;
    chk("reset busy", 64'(bus0.busy), 64'd0);
    chk("reset done", 64'(bus0.done), 64'd0);
    chk("reset product", bus0.product, 64'd0);
    chk("reset product dig8", bus1.product, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    scan = 1'b1;
    op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "unsigned max", 64'hFFFFFFFE00000001);
    op(1'b1, 32'hFFFFFFFF, 32'h00000003, 1'b0, "signed -1*3", 64'hFFFFFFFFFFFFFFFD);
    op(1'b1, 32'h80000000, 32'h80000000, 1'b0, "signed min^2", 64'h4000000000000000);
    @(negedge clk);
    go(1'b0, 32'h00001234, 32'h00000010, 1'b0);
    finish_op("stray start", 64'h0000000000012340, 2);
    go(1'b0, 32'h00000000, 32'hDEADBEEF, 1'b0);
    finish_op("start on done zero", 64'h0, -1);
    op(1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b0, "signed max*min", 64'hC000000080000000);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("idle reset product", bus0.product, 64'd0);
    chk("idle reset done", 64'(bus0.done), 64'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    go(1'b0, 32'd5, 32'd7, 1'b0);
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", 64'(bus0.busy), 64'd0);
    chk("abort done", 64'(bus0.done), 64'd0);
    chk("abort product", bus0.product, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    op(1'b0, 32'd6, 32'd7, 1'b0, "after abort", 64'd42);
    @(negedge clk);
    bus1.sgn = 1'b0;
    bus1.a = 32'h12345678;
    bus1.b = 32'h9ABCDEF0;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    n = 0;
    while (!bus1.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("dig8 latency", 64'(n), 64'd17);
    chk("dig8 product", bus1.product, 64'h0B00EA4E242D2080);
    @(negedge clk);
    chk("dig8 done pulse width", 64'(bus1.done), 64'd0);
`ifdef MULT_ITER_ACC_EN
    op(1'b0, 32'd3, 32'd4, 1'b0, "acc off", 64'd12);
    op(1'b0, 32'd5, 32'd6, 1'b1, "acc on", 64'd42);
    op(1'b1, 32'hFFFFFFFE, 32'd7, 1'b1, "acc signed", 64'd28);
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
